// File: rtl/core_inst_seq.sv
// Instruction sequencer for core: builds the 47-bit inst word for one kij pass
// (weight fill/load, activation fill, execute, OFIFO drain) or one psum accumulation sweep.
module core_inst_seq #(
    parameter int COL  = 8,
    parameter int ROW  = 8,
    parameter int IN_W = 6,
    parameter int K_W  = 3,
    parameter int GAP  = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_pass,
    input  logic [3:0]  kij,
    input  logic        start_acc,
    input  logic        ofifo_valid,
    output logic [46:0] inst,
    output logic        sfu_clr,
    output logic        out_strobe,
    output logic        busy,
    output logic        done
);
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_KIJ  = K_W * K_W;
    localparam int OUT_W    = IN_W - K_W + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;

    localparam logic [7:0]  T_WFILL   = 8'(COL);
    localparam logic [7:0]  T_WLOAD   = 8'(ROW + 2 * COL - 1);
    localparam logic [7:0]  T_GAP     = 8'(GAP - 1);
    localparam logic [7:0]  T_XFILL   = 8'(LEN_NIJ);
    localparam logic [7:0]  T_EXEC    = 8'(LEN_NIJ + ROW + COL);
    localparam logic [7:0]  T_SLOT    = 8'(LEN_KIJ + 2);
    localparam logic [7:0]  N_KIJ     = 8'(LEN_KIJ);
    localparam logic [7:0]  T_COL     = 8'(COL);
    localparam logic [7:0]  LAST_O    = 8'(LEN_ONIJ - 1);
    localparam logic [3:0]  KIJ_MAX   = 4'(LEN_KIJ - 1);
    localparam logic [3:0]  OCOL_MAX  = 4'(OUT_W - 1);
    localparam logic [3:0]  KW_MAX    = 4'(K_W - 1);
    localparam logic [10:0] NIJ_11    = 11'(LEN_NIJ);
    localparam logic [10:0] PB_ROW    = 11'(IN_W - OUT_W + 1);
    localparam logic [10:0] KO_COL    = 11'(LEN_NIJ + 1);
    localparam logic [10:0] KO_ROW    = 11'(LEN_NIJ + IN_W - K_W + 1);
    localparam logic [46:0] IDLE_WORD = 47'h6001800C0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WFILL, S_WLOAD, S_GAP, S_XFILL, S_EXEC, S_DRAIN, S_ACC, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  t, t_n, o, o_n;
    logic [10:0] n, n_n, base, base_n, pb, pb_n, ko, ko_n;
    logic [3:0]  ocol, ocol_n, kc, kc_n, kr, kr_n;
    logic [46:0] word;
    logic        clr_n, strobe_n;

    // Next state/counters, then the word for the cycle being entered.
    // pb tracks the output pixel's top-left input offset, ko the kernel tap's offset incl. kij bank.
    always_comb begin
        state_n  = state;
        t_n      = t + 8'd1;
        n_n      = n;
        base_n   = base;
        o_n      = o;
        ocol_n   = ocol;
        pb_n     = pb;
        kc_n     = kc;
        kr_n     = kr;
        ko_n     = ko;
        word     = IDLE_WORD;
        clr_n    = 1'b0;
        strobe_n = 1'b0;

        case (state)
            S_IDLE: begin
                t_n = 8'd0;
                if (start_pass && (kij <= KIJ_MAX)) begin
                    state_n = S_WFILL;
                    base_n  = NIJ_11 * {7'd0, kij};
                end else if (start_acc) begin
                    state_n = S_ACC;
                    o_n     = 8'd0;
                    ocol_n  = 4'd0;
                    pb_n    = 11'd0;
                    kc_n    = 4'd0;
                    kr_n    = 4'd0;
                    ko_n    = 11'd0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WFILL: if (t == T_WFILL) begin state_n = S_WLOAD; t_n = 8'd0; end
                     else begin state_n = S_WFILL; end
            S_WLOAD: if (t == T_WLOAD) begin state_n = S_GAP; t_n = 8'd0; end
                     else begin state_n = S_WLOAD; end
            S_GAP:   if (t == T_GAP) begin state_n = S_XFILL; t_n = 8'd0; end
                     else begin state_n = S_GAP; end
            S_XFILL: if (t == T_XFILL) begin state_n = S_EXEC; t_n = 8'd0; end
                     else begin state_n = S_XFILL; end
            S_EXEC: begin
                if (t == T_EXEC) begin
                    state_n = S_DRAIN;
                    t_n     = 8'd0;
                    n_n     = 11'd0;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_DRAIN: begin
                t_n = 8'd0;
                if (n == NIJ_11) begin state_n = S_DONE; end
                else begin state_n = S_DRAIN; end
            end
            S_ACC: begin
                if (t == T_SLOT) begin
                    t_n = 8'd0;
                    if (o == LAST_O) begin
                        state_n = S_DONE;
                    end else begin
                        o_n = o + 8'd1;
                        if (ocol == OCOL_MAX) begin
                            ocol_n = 4'd0;
                            pb_n   = pb + PB_ROW;
                        end else begin
                            ocol_n = ocol + 4'd1;
                            pb_n   = pb + 11'd1;
                        end
                    end
                end else begin
                    state_n = S_ACC;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                t_n     = 8'd0;
            end
            default: begin
                state_n = S_IDLE;
                t_n     = 8'd0;
            end
        endcase

        case (state_n)
            S_WFILL: begin
                if (t_n < T_COL) begin
                    word[19]   = 1'b0;
                    word[17:7] = 11'(t_n);
                end else begin
                    word[19] = 1'b1;
                end
                word[5] = (t_n != 8'd0);
            end
            S_WLOAD: begin
                word[4] = 1'b1;
                word[0] = (t_n != 8'd0);
            end
            S_XFILL: begin
                if (t_n < T_XFILL) begin
                    word[46]    = 1'b0;
                    word[44:34] = 11'(t_n);
                end else begin
                    word[46] = 1'b1;
                end
                word[2] = (t_n != 8'd0);
            end
            S_EXEC: begin
                word[3] = (t_n < T_EXEC);
                word[1] = (t_n != 8'd0);
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    word[6]     = 1'b1;
                    word[32]    = 1'b0;
                    word[31]    = 1'b0;
                    word[30:20] = base_n + n_n;
                    n_n         = n_n + 11'd1;
                end else begin
                    word[6] = 1'b0;
                end
            end
            S_ACC: begin
                clr_n    = (t_n == 8'd0);
                strobe_n = (t_n == T_SLOT);
                word[33] = (t_n >= 8'd2) && (t_n <= N_KIJ + 8'd1);
                if ((t_n != 8'd0) && (t_n <= N_KIJ)) begin
                    word[32]    = 1'b0;
                    word[30:20] = pb_n + ko;
                    if (kc == KW_MAX) begin
                        kc_n = 4'd0;
                        if (kr == KW_MAX) begin
                            kr_n = 4'd0;
                            ko_n = 11'd0;
                        end else begin
                            kr_n = kr + 4'd1;
                            ko_n = ko + KO_ROW;
                        end
                    end else begin
                        kc_n = kc + 4'd1;
                        ko_n = ko + KO_COL;
                    end
                end else begin
                    word[32] = 1'b1;
                end
            end
            default: word = IDLE_WORD;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            t          <= 8'd0;
            n          <= 11'd0;
            base       <= 11'd0;
            o          <= 8'd0;
            ocol       <= 4'd0;
            pb         <= 11'd0;
            kc         <= 4'd0;
            kr         <= 4'd0;
            ko         <= 11'd0;
            inst       <= IDLE_WORD;
            sfu_clr    <= 1'b0;
            out_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            t          <= t_n;
            n          <= n_n;
            base       <= base_n;
            o          <= o_n;
            ocol       <= ocol_n;
            pb         <= pb_n;
            kc         <= kc_n;
            kr         <= kr_n;
            ko         <= ko_n;
            inst       <= word;
            sfu_clr    <= clr_n;
            out_strobe <= strobe_n;
            busy       <= (state_n != S_IDLE) && (state_n != S_DONE);
            done       <= (state_n == S_DONE);
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: per-cycle trace check against a phase-level model, plus literal pins.
module tb_core_inst_seq;
    localparam int COL = 8, ROW = 8, IN_W = 6, K_W = 3, GAP = 11;
    localparam int LEN_NIJ = IN_W * IN_W, LEN_KIJ = K_W * K_W;
    localparam int OUT_W = IN_W - K_W + 1, LEN_ONIJ = OUT_W * OUT_W;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start_pass = 1'b0, start_acc = 1'b0, ofifo_valid = 1'b1;
    logic [3:0]  kij = 4'd0;
    logic [46:0] inst;
    logic        sfu_clr, out_strobe, busy, done;

    always #5 clk = ~clk;

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start_pass(start_pass), .kij(kij), .start_acc(start_acc),
        .ofifo_valid(ofifo_valid), .inst(inst), .sfu_clr(sfu_clr), .out_strobe(out_strobe),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [46:0] inst;
        logic        clr;
        logic        strobe;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_fail = 0;
    bit   chk_en = 1'b0;
    int   stall_at = -1, stall_len = 0;
    int   cnt_wr, cnt_load, cnt_l0w, cnt_exec, cnt_busy, done_cycle;
    int   drain_q[$], acc_q[$], strobe_q[$];

    function automatic bit valid_at(int e);
        return !((e >= stall_at) && (e < stall_at + stall_len));
    endfunction

    function automatic logic [46:0] idle_word();
        logic [46:0] w;
        w = '0;
        w[46] = 1'b1; w[45] = 1'b1; w[32] = 1'b1; w[31] = 1'b1; w[19] = 1'b1; w[18] = 1'b1;
        return w;
    endfunction

    function automatic void push(logic [46:0] w, logic c, logic s, logic b, logic d);
        exp_t x;
        x = {w, c, s, b, d};
        exp_q.push_back(x);
    endfunction

    // One kij pass, phase by phase, drain gated by the planned ofifo_valid pattern.
    function automatic void build_pass(int k);
        logic [46:0] w;
        int e, nr;
        push(idle_word(), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t <= COL; t++) begin
            w = idle_word();
            if (t < COL) begin w[19] = 1'b0; w[17:7] = 11'(t); end
            w[5] = (t >= 1);
            push(w, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int t = 0; t < ROW + 2 * COL; t++) begin
            w = idle_word(); w[4] = 1'b1; w[0] = (t >= 1);
            push(w, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int t = 0; t < GAP; t++) push(idle_word(), 1'b0, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t <= LEN_NIJ; t++) begin
            w = idle_word();
            if (t < LEN_NIJ) begin w[46] = 1'b0; w[44:34] = 11'(t); end
            w[2] = (t >= 1);
            push(w, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int t = 0; t <= LEN_NIJ + ROW + COL; t++) begin
            w = idle_word(); w[3] = (t <= LEN_NIJ + ROW + COL - 1); w[1] = (t >= 1);
            push(w, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        e  = (COL + 1) + (ROW + 2 * COL) + GAP + (LEN_NIJ + 1) + (LEN_NIJ + ROW + COL + 1);
        nr = 0;
        while (nr < LEN_NIJ) begin
            w = idle_word();
            if (valid_at(e)) begin
                w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(LEN_NIJ * k + nr);
                nr++;
            end
            push(w, 1'b0, 1'b0, 1'b1, 1'b0);
            e++;
        end
        push(idle_word(), 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Accumulation sweep, addresses straight from the row/column formula.
    function automatic void build_acc();
        logic [46:0] w;
        int k;
        push(idle_word(), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int o = 0; o < LEN_ONIJ; o++) begin
            for (int s = 0; s < LEN_KIJ + 3; s++) begin
                w = idle_word();
                if (s >= 1 && s <= LEN_KIJ) begin
                    k = s - 1;
                    w[32] = 1'b0;
                    w[30:20] = 11'(LEN_NIJ * k + (o / OUT_W + k / K_W) * IN_W + (o % OUT_W + k % K_W));
                end
                w[33] = (s >= 2 && s <= LEN_KIJ + 1);
                push(w, (s == 0), (s == LEN_KIJ + 2), 1'b1, 1'b0);
            end
        end
        push(idle_word(), 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Every cycle: the DUT outputs must equal the model's next word (idle once the model is exhausted).
    always @(negedge clk) begin : trace_chk
        exp_t ex, ac;
        if (chk_en) begin
            ex = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'({idle_word(), 4'b0000});
            ac = {inst, sfu_clr, out_strobe, busy, done};
            n_cmp++;
            if (ac !== ex) begin
                n_fail++;
                $display("FAIL trace @%0t: got inst=%h clr=%b str=%b busy=%b done=%b, expected inst=%h clr=%b str=%b busy=%b done=%b",
                         $time, ac.inst, ac.clr, ac.strobe, ac.busy, ac.done,
                         ex.inst, ex.clr, ex.strobe, ex.busy, ex.done);
            end
        end
    end

    task automatic run_op(input bit dp, input bit da, input logic [3:0] k, input int s_at, input int s_len,
                          input int poke_at, input int rst_at, input int exp_done, input int max_e);
        @(posedge clk); #2;
        stall_at = s_at; stall_len = s_len;
        cnt_wr = 0; cnt_load = 0; cnt_l0w = 0; cnt_exec = 0; cnt_busy = 0; done_cycle = -1;
        drain_q.delete(); acc_q.delete(); strobe_q.delete();
        if (dp && (k < 4'(LEN_KIJ))) build_pass(int'(k));
        else if (da) build_acc();
        start_pass = dp; start_acc = da; kij = k; ofifo_valid = valid_at(0);
        for (int e = 0; e < max_e; e++) begin
            @(posedge clk); #2;
            start_pass = 1'b0;
            start_acc = (e == poke_at);
            ofifo_valid = valid_at(e + 1);
            if (rst_at >= 0 && e == rst_at) begin
                reset = 1'b1;
                while (exp_q.size() > 1) void'(exp_q.pop_back());
            end
            if (rst_at >= 0 && e == rst_at + 3) reset = 1'b0;
            if (rst_at >= 0 && e == rst_at + 1) begin
                check("reset_inst", 64'(inst), 64'h6001800C0000);
                check("reset_busy", 64'(busy), 64'd0);
            end
            if (inst[5]) cnt_wr++;
            if (inst[0]) cnt_load++;
            if (inst[2]) cnt_l0w++;
            if (inst[1]) cnt_exec++;
            if (busy) cnt_busy++;
            if (inst[6]) drain_q.push_back(int'(inst[30:20]));
            if (!inst[32] && inst[31]) acc_q.push_back(int'(inst[30:20]));
            if (out_strobe) strobe_q.push_back(e);
            if (done && done_cycle < 0) done_cycle = e;
            if (done_cycle >= 0 && e >= done_cycle + 2) break;
        end
        start_acc = 1'b0; start_pass = 1'b0; reset = 1'b0;
        check("done_cycle", 64'(done_cycle), 64'(exp_done));
    endtask

    task automatic check_drain(input int first, input int last);
        int breaks;
        breaks = 0;
        check("drain_reads", 64'(drain_q.size()), 64'd36);
        if (drain_q.size() == 36) begin
            check("drain_first", 64'(drain_q[0]), 64'(first));
            check("drain_last", 64'(drain_q[35]), 64'(last));
            for (int i = 1; i < 36; i++) if (drain_q[i] != drain_q[i-1] + 1) breaks++;
            check("drain_contig", 64'(breaks), 64'd0);
        end
    endtask

    initial begin : stim
        int o0_addr[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
        int bad_gap;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        check("init_inst", 64'(inst), 64'h6001800C0000);
        check("init_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_op(1'b1, 1'b0, 4'd2, -1, 0, -1, -1, 170, 400);
        check("ififo_wr_cnt", 64'(cnt_wr), 64'd8);
        check("load_cnt", 64'(cnt_load), 64'd23);
        check("l0_wr_cnt", 64'(cnt_l0w), 64'd36);
        check("exec_cnt", 64'(cnt_exec), 64'd52);
        check("busy_cnt", 64'(cnt_busy), 64'd170);
        check_drain(72, 107);

        run_op(1'b1, 1'b0, 4'd2, 150, 5, -1, -1, 175, 400);
        check_drain(72, 107);

        run_op(1'b0, 1'b1, 4'd0, -1, 0, -1, -1, 192, 400);
        check("strobe_cnt", 64'(strobe_q.size()), 64'd16);
        bad_gap = 0;
        for (int i = 1; i < strobe_q.size(); i++) if (strobe_q[i] - strobe_q[i-1] != 12) bad_gap++;
        check("strobe_gap", 64'(bad_gap), 64'd0);
        check("acc_reads", 64'(acc_q.size()), 64'd144);
        if (acc_q.size() == 144) begin
            for (int i = 0; i < 9; i++) check("acc_o0_addr", 64'(acc_q[i]), 64'(o0_addr[i]));
            check("acc_o15_last", 64'(acc_q[143]), 64'd323);
            check("acc_o5_k4", 64'(acc_q[5 * 9 + 4]), 64'd158);
        end

        run_op(1'b1, 1'b0, 4'd9, -1, 0, -1, -1, -1, 12);
        check("bad_kij_busy", 64'(cnt_busy), 64'd0);

        run_op(1'b1, 1'b1, 4'd2, -1, 0, -1, -1, 170, 400);
        check("both_acc_strobes", 64'(strobe_q.size()), 64'd0);
        check_drain(72, 107);

        run_op(1'b1, 1'b0, 4'd0, -1, 0, 50, -1, 170, 400);
        check_drain(0, 35);

        run_op(1'b1, 1'b0, 4'd8, -1, 0, -1, 100, -1, 108);

        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
